// File: rtl/secure_serdes_decryptor_rx.sv
// Receive-side deserialiser: rebuilds MSB-first cipher bytes, strips the key byte,
// and queues recovered bytes in a small FIFO drained over valid/ready.
module secure_serdes_decryptor_rx #(
  parameter logic [7:0]  KEY_BYTE = 8'h34,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       cipher_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       frame_err,
  input  logic       err_clr,
  output logic [7:0] frame_count
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
  localparam logic [7:0]  IDLE_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RECV, PUSH} state_t;

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [7:0]    mem_q [DEPTH];

  logic full, empty, pop, push, drop, timeout_hit;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    byte_d      = byte_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_valid) begin
          shreg_d    = {shreg_q[6:0], cipher_in};
          bit_cnt_d  = 4'd1;
          idle_cnt_d = '0;
          state_d    = RECV;
        end
      end
      RECV: begin
        if (bit_valid) begin
          shreg_d    = {shreg_q[6:0], cipher_in};
          idle_cnt_d = '0;
          if (bit_cnt_q == 4'd7) begin
            byte_d    = {shreg_q[6:0], cipher_in} ^ KEY_BYTE;
            bit_cnt_d = '0;
            state_d   = PUSH;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          timeout_hit = 1'b1;
          shreg_d     = '0;
          bit_cnt_d   = '0;
          idle_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      PUSH: begin
        // A bit arriving during the write cycle starts the next frame directly.
        if (bit_valid) begin
          shreg_d    = {shreg_q[6:0], cipher_in};
          bit_cnt_d  = 4'd1;
          idle_cnt_d = '0;
          state_d    = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    pop   = out_ready && !empty;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    push  = (state_q == PUSH) && (!full || pop);
    drop  = (state_q == PUSH) && full && !pop;

    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    frame_count_d = push ? frame_count_q + 8'd1 : frame_count_q;
    overflow_d    = (overflow_q  && !err_clr) || drop;
    frame_err_d   = (frame_err_q && !err_clr) || timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      byte_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_q        <= byte_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_q;
  end

  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_secure_serdes_decryptor_rx.sv
// Bench for secure_serdes_decryptor_rx: directed sequences, a decode table,
// and randomized traffic, all compared cycle-by-cycle with a queue-based model.
module tb_secure_serdes_decryptor_rx;

  localparam logic [7:0]  KEY     = 8'h34;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_valid, cipher_in, out_ready, err_clr;
  logic [7:0] out_data, frame_count;
  logic       out_valid, overflow, frame_err;

  secure_serdes_decryptor_rx #(.KEY_BYTE(KEY), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .cipher_in(cipher_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .frame_err(frame_err), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a byte queue plus a bit accumulator for the frame in flight.
  logic [7:0] q_m[$];
  int         m_nbits, m_idle;
  logic [7:0] m_acc, m_pbyte, m_fc;
  bit         m_pend, m_ovf, m_ferr;

  typedef struct {
    logic [7:0] cipher;
    logic [7:0] plain;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_m.delete();
    m_nbits = 0; m_idle = 0; m_acc = '0; m_pbyte = '0; m_fc = '0;
    m_pend = 0; m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_step(input bit bv, input bit ci, input bit rdy, input bit clr);
    bit do_pop, was_full, ovf_ev, ferr_ev;
    do_pop   = rdy && (q_m.size() > 0);
    was_full = (q_m.size() == DEPTH);
    ovf_ev   = 0;
    ferr_ev  = 0;
    if (do_pop) void'(q_m.pop_front());
    if (m_pend) begin
      if (!was_full || do_pop) begin
        q_m.push_back(m_pbyte);
        m_fc = m_fc + 8'd1;
      end else ovf_ev = 1;
      m_pend = 0;
    end
    if (bv) begin
      m_acc = 8'((m_acc * 2) + ci);
      m_nbits++;
      m_idle = 0;
      if (m_nbits == 8) begin
        m_pend  = 1;
        m_pbyte = m_acc ^ KEY;
        m_nbits = 0;
      end
    end else if (m_nbits > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        ferr_ev = 1;
        m_nbits = 0;
        m_idle  = 0;
      end
    end
    m_ovf  = (m_ovf  && !clr) || ovf_ev;
    m_ferr = (m_ferr && !clr) || ferr_ev;
  endtask

  function automatic logic [31:0] dut_vec();
    return {13'd0, out_valid, overflow, frame_err, out_data, frame_count};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [7:0] head;
    head = (q_m.size() > 0) ? q_m[0] : 8'h00;
    return {13'd0, q_m.size() > 0, m_ovf, m_ferr, head, m_fc};
  endfunction

  // Called just after an edge; applies inputs for one full cycle, then compares.
  task automatic tick(input bit bv, input bit ci, input bit rdy, input bit clr);
    bit_valid = bv; cipher_in = ci; out_ready = rdy; err_clr = clr;
    @(posedge clk);
    model_step(bv, ci, rdy, clr);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic send_frame(input logic [7:0] c, input bit rdy);
    logic [7:0] v;
    v = c;
    for (int i = 7; i >= 0; i--) tick(1'b1, v[i], rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bit_valid = 0; cipher_in = 0; out_ready = 0; err_clr = 0;
    @(posedge clk);
    #1;
    model_clear();
    chk("reset_state", dut_vec(), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_heads[4];
    vecs[0] = '{8'h61, 8'h55}; vecs[1] = '{8'hB4, 8'h80};
    vecs[2] = '{8'h35, 8'h01}; vecs[3] = '{8'h34, 8'h00};
    vecs[4] = '{8'h00, 8'h34}; vecs[5] = '{8'hFF, 8'hCB};
    vecs[6] = '{8'hA5, 8'h91}; vecs[7] = '{8'h5A, 8'h6E};
    model_clear();
    do_reset();

    // Basic decrypt and write latency
    send_frame(8'h61, 1'b1);
    chk("basic_not_yet_valid", out_valid, 1'b0);
    tick(0, 0, 1, 0);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_data", out_data, 8'h55);
    chk("basic_count", frame_count, 8'd1);
    tick(0, 0, 1, 0);
    chk("basic_drained", out_valid, 1'b0);

    // Decode table
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].cipher, 1'b0);
      tick(0, 0, 0, 0);
      chk("table_data", out_data, vecs[i].plain);
      tick(0, 0, 1, 0);
      chk("table_empty", out_valid, 1'b0);
    end

    // Overflow: fifth back-to-back frame dropped
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(8'h35 + 8'(i), 1'b0);
    tick(0, 0, 0, 0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_count", frame_count, 8'd4);
    exp_heads = '{8'h01, 8'h02, 8'h03, 8'h0C};
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pop_order", out_data, exp_heads[i]);
      tick(0, 0, 1, 0);
    end
    chk("ovf_empty", out_valid, 1'b0);

    // Timeout boundary, recovery frame, err_clr
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(0, 0, 0, 0);
    chk("timeout_not_early", frame_err, 1'b0);
    tick(0, 0, 0, 0);
    chk("timeout_flag", frame_err, 1'b1);
    chk("timeout_no_push", out_valid, 1'b0);
    send_frame(8'h34, 1'b0);
    tick(0, 0, 0, 0);
    chk("timeout_next_data", out_data, 8'h00);
    chk("timeout_next_valid", out_valid, 1'b1);
    tick(0, 0, 0, 1);
    chk("errclr_frame_err", frame_err, 1'b0);

    // Back-to-back frames with bit_valid held high
    do_reset();
    send_frame(8'hB4, 1'b0);
    send_frame(8'h35, 1'b0);
    tick(0, 0, 0, 0);
    chk("b2b_count", frame_count, 8'd2);
    chk("b2b_first", out_data, 8'h80);
    tick(0, 0, 1, 0);
    chk("b2b_second", out_data, 8'h01);

    // Full FIFO with pop on the push cycle
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(8'h35 + 8'(i), 1'b0);
    tick(0, 0, 0, 0);
    send_frame(8'h39, 1'b0);
    tick(0, 0, 1, 0);
    chk("fullpop_no_ovf", overflow, 1'b0);
    chk("fullpop_count", frame_count, 8'd5);
    exp_heads = '{8'h02, 8'h03, 8'h0C, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_order", out_data, exp_heads[i]);
      tick(0, 0, 1, 0);
    end
    chk("fullpop_empty", out_valid, 1'b0);

    // Asynchronous reset mid-frame
    do_reset();
    send_frame(8'h35, 1'b0);
    send_frame(8'h36, 1'b0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
    chk("prereset_fill", frame_count, 8'd2);
    bit_valid = 0; cipher_in = 0;
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", dut_vec(), 32'd0);
    #1 rst = 1'b0;
    model_clear();
    @(posedge clk);
    model_step(0, 0, 0, 0);
    #1;
    send_frame(8'hA5, 1'b0);
    tick(0, 0, 0, 0);
    chk("post_reset_data", out_data, 8'h91);
    chk("post_reset_count", frame_count, 8'd1);

    // Randomized traffic against the model
    do_reset();
    for (int seg = 0; seg < 12; seg++) begin
      int unsigned p;
      p = (seg % 3 == 0) ? 90 : (seg % 3 == 1) ? 50 : 4;
      for (int c = 0; c < 150; c++) begin
        tick($urandom_range(99, 0) < p, $urandom_range(1, 0) == 1,
             $urandom_range(99, 0) < 45, $urandom_range(99, 0) < 5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
